// File: rtl/tdm_slot_arbiter.sv
// TDM slot arbiter: grants one of four requesters per occurrence of its slot,
// counts grants per channel, and flags illegal ring-counter phase patterns.
module tdm_slot_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         phase,
  input  logic [3:0]         req,
  input  logic               clr,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               err_onehot,
  output logic               err_seq,
  output logic [4*CNT_W-1:0] cnt_flat
);

  function automatic logic is_onehot(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] rotl1(input logic [3:0] p);
    return {p[2:0], p[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic [3:0]       prev_phase;
  logic             prev_valid;
  logic             slot_used;
  logic [CNT_W-1:0] cnt [4];

  logic             legal;
  logic             occ_start;
  logic             seq_bad;
  logic             used_eff;
  logic [3:0]       gnt_n;
  logic             slot_used_n;
  logic [3:0]       prev_phase_n;
  logic             prev_valid_n;
  logic             err_onehot_n;
  logic             err_seq_n;

  assign busy = |req;

  // Phase qualification, occurrence detection and grant decision
  always_comb begin
    legal        = is_onehot(phase);
    occ_start    = 1'b0;
    seq_bad      = 1'b0;
    used_eff     = slot_used;
    gnt_n        = 4'd0;
    slot_used_n  = slot_used;
    prev_phase_n = prev_phase;
    prev_valid_n = 1'b0;
    if (legal) begin
      occ_start    = !prev_valid || (phase != prev_phase);
      seq_bad      = prev_valid && (phase != prev_phase) && (phase != rotl1(prev_phase));
      used_eff     = occ_start ? 1'b0 : slot_used;
      gnt_n        = used_eff ? 4'd0 : (phase & req);
      slot_used_n  = used_eff || (gnt_n != 4'd0);
      prev_phase_n = phase;
      prev_valid_n = 1'b1;
    end
    // A newly detected error wins over a simultaneous clear
    err_onehot_n = !legal || (err_onehot && !clr);
    err_seq_n    = seq_bad || (err_seq && !clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= 4'd0;
      prev_phase <= 4'd0;
      prev_valid <= 1'b0;
      slot_used  <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
    end else begin
      gnt        <= gnt_n;
      prev_phase <= prev_phase_n;
      prev_valid <= prev_valid_n;
      slot_used  <= slot_used_n;
      err_onehot <= err_onehot_n;
      err_seq    <= err_seq_n;
    end
  end

  // Counters advance while the grant pulse is on the output; clear beats increment
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst || clr)
        cnt[k] <= '0;
      else if (gnt[k])
        cnt[k] <= sat_inc(cnt[k]);
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int k = 0; k < 4; k++)
      cnt_flat[k*CNT_W +: CNT_W] = cnt[k];
  end

endmodule

// File: tb/tb_tdm_slot_arbiter.sv
// Directed bench for tdm_slot_arbiter: vector table plus a saturation sequence
// on a narrow-counter instance driven in parallel.
module tb_tdm_slot_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  phase;
  logic [3:0]  req;
  logic        clr;
  logic [3:0]  gnt;
  logic        busy;
  logic        err_onehot;
  logic        err_seq;
  logic [31:0] cnt_flat;
  logic [3:0]  gnt2;
  logic        busy2;
  logic        err_onehot2;
  logic        err_seq2;
  logic [7:0]  cnt_flat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_slot_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .phase(phase), .req(req), .clr(clr),
    .gnt(gnt), .busy(busy), .err_onehot(err_onehot), .err_seq(err_seq),
    .cnt_flat(cnt_flat)
  );

  tdm_slot_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .phase(phase), .req(req), .clr(clr),
    .gnt(gnt2), .busy(busy2), .err_onehot(err_onehot2), .err_seq(err_seq2),
    .cnt_flat(cnt_flat2)
  );

  typedef struct packed {
    logic        rst;
    logic        clr;
    logic [3:0]  phase;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        busy;
    logic        eo;
    logic        es;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [3:0] p, input logic [3:0] q);
    @(negedge clk);
    rst = r; clr = c; phase = p; req = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst   clr   phase    req      gnt      busy  eo    es    cnt_flat
    vecs[0]  = '{1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b0, 4'b0001, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b0, 4'b0010, 4'b1111, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h00000001};
    vecs[3]  = '{1'b0, 1'b0, 4'b0100, 4'b1111, 4'b0100, 1'b1, 1'b0, 1'b0, 32'h00000101};
    vecs[4]  = '{1'b0, 1'b0, 4'b1000, 4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 32'h00010101};
    vecs[5]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h01010101};
    vecs[6]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 32'h01010101};
    vecs[7]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h01010201};
    vecs[8]  = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h01010201};
    vecs[9]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h01010201};
    vecs[10] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h01010201};
    vecs[11] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h01010201};
    vecs[12] = '{1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h01010201};
    vecs[13] = '{1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h01010201};
    vecs[14] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 32'h01010201};
    vecs[15] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h00000000};
    vecs[16] = '{1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h00000000};
    vecs[17] = '{1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[18] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h00000000};
    vecs[19] = '{1'b0, 1'b1, 4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[20] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[21] = '{1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h00000000};
    vecs[22] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b0, 32'h00000000};
    vecs[23] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h00010000};

    rst = 1'b1; clr = 1'b0; phase = 4'b0000; req = 4'b0000;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].phase, vecs[i].req);
      check($sformatf("v%0d gnt", i),        {28'd0, gnt},        {28'd0, vecs[i].gnt});
      check($sformatf("v%0d busy", i),       {31'd0, busy},       {31'd0, vecs[i].busy});
      check($sformatf("v%0d err_onehot", i), {31'd0, err_onehot}, {31'd0, vecs[i].eo});
      check($sformatf("v%0d err_seq", i),    {31'd0, err_seq},    {31'd0, vecs[i].es});
      check($sformatf("v%0d cnt_flat", i),   cnt_flat,            vecs[i].cnt);
    end

    // Saturation: channel 3 granted five times across full rotations
    step(1'b1, 1'b0, 4'b0001, 4'b0000);
    check("sat reset cnt2", {24'd0, cnt_flat2}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] ph;
      ph = 4'b0001 << (i % 4);
      step(1'b0, 1'b0, ph, 4'b1000);
      check($sformatf("sat r%0d gnt", i), {28'd0, gnt2}, (i % 4 == 3) ? 32'd8 : 32'd0);
      if (i == 12)
        check("sat cnt3 after 3", {30'd0, cnt_flat2[7:6]}, 32'd3);
    end
    step(1'b0, 1'b0, 4'b0001, 4'b0000);
    check("sat cnt3 narrow", {30'd0, cnt_flat2[7:6]}, 32'd3);
    check("sat other narrow", {26'd0, cnt_flat2[5:0]}, 32'd0);
    check("sat cnt3 wide", {24'd0, cnt_flat[31:24]}, 32'd5);
    check("sat errs", {30'd0, err_onehot2, err_seq2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
